msg_frame_decoder: RTL and testbench

- Downstream consumer of the image-processing message FIFO stream.
- Receives the fixed 31-word message: six colour bounding-box x-extent pairs, 28 edge x-coordinates, and the separator words between them.
- Checks the framing and unpacks the data words.
- Commits each complete message atomically into a snapshot bank, which the rover controller reads through an index port.
- Counts malformed messages and aborts messages that stall mid-frame.

---
 rtl/msg_frame_decoder.sv | 256 +++++++++++++++++++++++++
 tb/tb_msg_frame_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_frame_decoder.sv
// msg_frame_decoder
// Consumes the 31-word image-processing message stream, checks its framing,
// unpacks the 20 data words into a shadow bank and commits a complete message
// atomically into the snapshot bank that the rover controller reads.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   msg_valid      msg_data carries a word
//   msg_data       message word
//   msg_ready      decoder accepts a word (low only during COMMIT)
//   rd_index       snapshot entry select, 0..19 (others read as 0)
//   rd_data        {lo, hi} of the selected entry, one cycle latency
//   snap_valid     at least one message has been committed
//   frame_done     one-cycle pulse per commit
//   colour_present per colour entry 0..5: lo <= hi in the committed snapshot
//   err_count      saturating count of aborted messages
//   msg_count      wrapping count of committed messages
module msg_frame_decoder #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned IMAGE_W = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    output logic        msg_ready,
    input  logic [4:0]  rd_index,
    output logic [21:0] rd_data,
    output logic        snap_valid,
    output logic        frame_done,
    output logic [5:0]  colour_present,
    output logic [7:0]  err_count,
    output logic [15:0] msg_count
);

    localparam int unsigned N_ENTRIES = 20;
    localparam int unsigned N_COLOURS = 6;
    localparam int unsigned COORD_W   = 11;
    localparam int unsigned ENTRY_W   = 2 * COORD_W;
    localparam int unsigned POS_W     = 5;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned ERR_W     = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned TMR_W     = $clog2(TIMEOUT) + 1;

    localparam logic [POS_W-1:0]   LAST_POS  = POS_W'(30);
    localparam logic [31:0]        HEADER    = 32'hAAAA_AAAA;
    localparam logic [COORD_W-1:0] COORD_LIM = COORD_W'(IMAGE_W);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [POS_W-1:0]   pos_q;
    logic [POS_W-1:0]   pos_d;
    logic [IDX_W-1:0]   entry_q;
    logic [IDX_W-1:0]   entry_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;

    logic [ENTRY_W-1:0] shadow   [N_ENTRIES];
    logic [ENTRY_W-1:0] snapshot [N_ENTRIES];

    logic               xfer;
    logic [COORD_W-1:0] word_lo;
    logic [COORD_W-1:0] word_hi;
    logic               data_ok;
    logic               is_sep;
    logic [31:0]        sep_word;
    logic               bad_word;
    logic               err_inc;
    logic               shadow_we;
    logic               commit;

    // Word acceptance and data-word field extraction
    assign xfer    = msg_valid & msg_ready;
    assign word_lo = msg_data[26:16];
    assign word_hi = msg_data[10:0];
    assign data_ok = (msg_data[31:27] == 5'd0) && (msg_data[15:11] == 5'd0) &&
                     (word_lo < COORD_LIM) && (word_hi < COORD_LIM);

    // Separator positions and the word each one must carry
    always_comb begin
        is_sep   = 1'b1;
        sep_word = 32'h0000_0000;
        case (pos_q)
            5'd0:    sep_word = HEADER;
            5'd3:    sep_word = 32'hBBBB_BBBB;
            5'd6:    sep_word = 32'hCCCC_CCCC;
            5'd9:    sep_word = 32'h1111_1111;
            5'd12:   sep_word = 32'h2222_2222;
            5'd15:   sep_word = 32'h3333_3333;
            5'd18:   sep_word = 32'h4444_4444;
            5'd21:   sep_word = 32'h5555_5555;
            5'd24:   sep_word = 32'h6666_6666;
            5'd27:   sep_word = 32'h7777_7777;
            5'd30:   sep_word = 32'h8888_8888;
            default: is_sep   = 1'b0;
        endcase
    end

    // Next-state, position, idle timer and per-cycle action strobes
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        entry_d   = entry_q;
        timer_d   = timer_q;
        bad_word  = 1'b0;
        err_inc   = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;

        case (state_q)
            HUNT: begin
                if (xfer && (msg_data == HEADER)) begin
                    state_d = RECV;
                    pos_d   = POS_W'(1);
                    entry_d = '0;
                    timer_d = '0;
                end
            end

            RECV: begin
                if (xfer) begin
                    timer_d = '0;
                    if (is_sep) begin
                        if (msg_data == sep_word) begin
                            if (pos_q == LAST_POS) begin
                                state_d = COMMIT;
                                pos_d   = '0;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            bad_word = 1'b1;
                        end
                    end else if (data_ok) begin
                        shadow_we = 1'b1;
                        pos_d     = pos_q + POS_W'(1);
                        entry_d   = entry_q + IDX_W'(1);
                    end else begin
                        bad_word = 1'b1;
                    end

                    // A stray header restarts the frame instead of dropping to HUNT
                    if (bad_word) begin
                        err_inc = 1'b1;
                        entry_d = '0;
                        if (msg_data == HEADER) begin
                            pos_d = POS_W'(1);
                        end else begin
                            state_d = HUNT;
                            pos_d   = '0;
                        end
                    end
                end else if (timer_q == TMR_LAST) begin
                    err_inc = 1'b1;
                    state_d = HUNT;
                    pos_d   = '0;
                    entry_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            COMMIT: begin
                commit  = 1'b1;
                state_d = HUNT;
            end

            default: begin
                state_d = HUNT;
                pos_d   = '0;
                entry_d = '0;
                timer_d = '0;
            end
        endcase
    end

    // FSM state, framing counters and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= HUNT;
            pos_q          <= '0;
            entry_q        <= '0;
            timer_q        <= '0;
            msg_ready      <= 1'b0;
            frame_done     <= 1'b0;
            snap_valid     <= 1'b0;
            err_count      <= '0;
            msg_count      <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            entry_q    <= entry_d;
            timer_q    <= timer_d;
            msg_ready  <= (state_d != COMMIT);
            frame_done <= commit;
            if (err_inc && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (commit) begin
                snap_valid <= 1'b1;
                msg_count  <= msg_count + CNT_W'(1);
            end
        end
    end

    // Shadow bank collects the frame in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                shadow[i] <= '0;
            end
        end else if (shadow_we) begin
            shadow[entry_q] <= {word_lo, word_hi};
        end
    end

    // Snapshot bank and colour flags change only on commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                snapshot[i] <= '0;
            end
            colour_present <= '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                snapshot[i] <= shadow[i];
            end
            for (int unsigned c = 0; c < N_COLOURS; c++) begin
                colour_present[c] <= (shadow[c][ENTRY_W-1:COORD_W] <= shadow[c][COORD_W-1:0]);
            end
        end
    end

    // Registered read port; sees the pre-commit snapshot during COMMIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_index < IDX_W'(N_ENTRIES)) begin
            rd_data <= snapshot[rd_index];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_msg_frame_decoder.sv
// Self-checking bench for msg_frame_decoder with a message-level reference model.
module tb_msg_frame_decoder;

    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned IMAGE_W = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        msg_valid = 1'b0;
    logic [31:0] msg_data = 32'h0;
    logic        msg_ready;
    logic [4:0]  rd_index = 5'd0;
    logic [21:0] rd_data;
    logic        snap_valid;
    logic        frame_done;
    logic [5:0]  colour_present;
    logic [7:0]  err_count;
    logic [15:0] msg_count;

    msg_frame_decoder #(.TIMEOUT(TIMEOUT), .IMAGE_W(IMAGE_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .msg_valid      (msg_valid),
        .msg_data       (msg_data),
        .msg_ready      (msg_ready),
        .rd_index       (rd_index),
        .rd_data        (rd_data),
        .snap_valid     (snap_valid),
        .frame_done     (frame_done),
        .colour_present (colour_present),
        .err_count      (err_count),
        .msg_count      (msg_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [21:0] exp_snap [20];
    logic [5:0]  exp_colour = 6'd0;
    logic [7:0]  exp_err    = 8'd0;
    logic [15:0] exp_cnt    = 16'd0;
    logic        exp_valid  = 1'b0;

    logic [10:0] pair_lo [20];
    logic [10:0] pair_hi [20];
    logic [31:0] words   [31];
    logic [31:0] a_words [31];
    logic [31:0] seps    [11] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC,
                                  32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                  32'h4444_4444, 32'h5555_5555, 32'h6666_6666,
                                  32'h7777_7777, 32'h8888_8888};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        msg_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic random_pairs();
        for (int i = 0; i < 20; i++) begin
            pair_lo[i] = 11'($urandom_range(0, IMAGE_W - 1));
            pair_hi[i] = 11'($urandom_range(0, IMAGE_W - 1));
        end
    endtask

    // Interleave separators (every third position) with data words
    task automatic build_msg();
        int e = 0;
        for (int p = 0; p < 31; p++) begin
            if (p % 3 == 0) begin
                words[p] = seps[p / 3];
            end else begin
                words[p] = {5'd0, pair_lo[e], 5'd0, pair_hi[e]};
                e++;
            end
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < 20; i++) exp_snap[i] = {pair_lo[i], pair_hi[i]};
        for (int c = 0; c < 6; c++) exp_colour[c] = (pair_lo[c] <= pair_hi[c]);
        exp_cnt   = exp_cnt + 16'd1;
        exp_valid = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 20; i++) exp_snap[i] = 22'd0;
        exp_colour = 6'd0;
        exp_err    = 8'd0;
        exp_cnt    = 16'd0;
        exp_valid  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        int guard = 0;
        msg_valid = 1'b1;
        msg_data  = w;
        while (msg_ready !== 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        if (guard >= 8) check("ready_wait", 32'(msg_ready), 32'd1);
        step();
    endtask

    task automatic send_range(input int from, input int upto, input int max_gap);
        for (int p = from; p <= upto; p++) begin
            send_word(words[p]);
            if (max_gap > 0 && p != upto) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_snapshot(input string tag);
        msg_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_index = 5'(i);
            step();
            check(tag, 32'(rd_data), 32'(exp_snap[i]));
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_err"}, 32'(err_count), 32'(exp_err));
        check({tag, "_cnt"}, 32'(msg_count), 32'(exp_cnt));
        check({tag, "_fd"},  32'(frame_done), 32'd0);
    endtask

    // Called right after the closing separator was transferred
    task automatic finish_commit(input string tag);
        check({tag, "_ready_low"}, 32'(msg_ready), 32'd0);
        check({tag, "_fd_early"}, 32'(frame_done), 32'd0);
        msg_valid = 1'b0;
        rd_index  = 5'd0;
        step();
        check({tag, "_fd_pulse"}, 32'(frame_done), 32'd1);
        check({tag, "_rd_old"}, 32'(rd_data), 32'(exp_snap[0]));
        model_commit();
        check({tag, "_cnt"}, 32'(msg_count), 32'(exp_cnt));
        check({tag, "_colour"}, 32'(colour_present), 32'(exp_colour));
        check({tag, "_snapv"}, 32'(snap_valid), 32'd1);
        step();
        check({tag, "_fd_end"}, 32'(frame_done), 32'd0);
        check({tag, "_rd_new"}, 32'(rd_data), 32'(exp_snap[0]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2 reset = 1'b1;
        step();
        check("rst_ready", 32'(msg_ready), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_snapv", 32'(snap_valid), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_colour", 32'(colour_present), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_cnt", 32'(msg_count), 32'd0);
        reset = 1'b0;
        step();
        check("ready_after_rst", 32'(msg_ready), 32'd1);

        // Directed valid message with known colour and edge values
        random_pairs();
        pair_lo[0] = 11'd100; pair_hi[0] = 11'd200;
        for (int c = 1; c < 5; c++) begin
            pair_lo[c] = 11'($urandom_range(0, 300));
            pair_hi[c] = pair_lo[c] + 11'($urandom_range(0, 339));
        end
        pair_lo[5] = 11'd639; pair_hi[5] = 11'd0;
        for (int k = 0; k < 14; k++) begin
            pair_lo[6 + k] = 11'(10 * (2 * k + 1));
            pair_hi[6 + k] = 11'(10 * (2 * k + 2));
        end
        build_msg();
        send_range(0, 30, 0);
        finish_commit("m1");
        check("m1_cnt1", 32'(msg_count), 32'd1);
        check("m1_colour", 32'(colour_present), 32'b011111);
        check("m1_rd0", 32'(rd_data), 32'({11'd100, 11'd200}));
        rd_index = 5'd19; step();
        check("m1_rd19", 32'(rd_data), 32'({11'd270, 11'd280}));
        rd_index = 5'd20; step();
        check("m1_rd20", 32'(rd_data), 32'd0);
        rd_index = 5'd31; step();
        check("m1_rd31", 32'(rd_data), 32'd0);

        // Wrong separator at position 3
        random_pairs(); build_msg();
        words[3] = 32'hBBBB_BBBA;
        send_range(0, 3, 0);
        exp_err = sat_inc(exp_err);
        idle(3);
        check_status("badsep");
        check_snapshot("badsep_snap");
        random_pairs(); build_msg();
        send_range(0, 30, 0);
        finish_commit("after_badsep");
        check_snapshot("after_badsep_snap");

        // Header arriving at position 12 restarts the frame
        random_pairs(); build_msg();
        a_words = words;
        random_pairs(); build_msg();
        for (int p = 0; p < 12; p++) send_word(a_words[p]);
        send_word(32'hAAAA_AAAA);
        exp_err = sat_inc(exp_err);
        check("resync_err", 32'(err_count), 32'(exp_err));
        send_range(1, 30, 0);
        finish_commit("resync");
        check_snapshot("resync_snap");

        // Out-of-range coordinate in a data word
        random_pairs(); build_msg();
        words[4] = 32'h0280_0010;
        send_range(0, 4, 0);
        exp_err = sat_inc(exp_err);
        check("fmt_err", 32'(err_count), 32'(exp_err));
        send_range(5, 30, 0);
        idle(2);
        check_status("fmt");
        check_snapshot("fmt_snap");

        // Idle timeout after the sixth word
        random_pairs(); build_msg();
        send_range(0, 5, 0);
        idle(TIMEOUT - 1);
        check("tmo_before", 32'(err_count), 32'(exp_err));
        step();
        exp_err = sat_inc(exp_err);
        check("tmo_after", 32'(err_count), 32'(exp_err));
        send_range(6, 30, 0);
        idle(2);
        check_status("tmo_late");
        check_snapshot("tmo_snap");

        // Random messages with short gaps between words
        for (int m = 0; m < 4; m++) begin
            random_pairs(); build_msg();
            send_range(0, 30, 2);
            finish_commit("rand");
            for (int r = 0; r < 3; r++) begin
                int idx = $urandom_range(0, 19);
                rd_index = 5'(idx); step();
                check("rand_rd", 32'(rd_data), 32'(exp_snap[idx]));
            end
        end

        // Back-to-back messages; the next header is held through COMMIT
        random_pairs(); build_msg();
        send_range(0, 30, 0);
        model_commit();
        random_pairs(); build_msg();
        send_range(0, 30, 0);
        model_commit();
        idle(2);
        check("b2b_cnt", 32'(msg_count), 32'(exp_cnt));
        check("b2b_colour", 32'(colour_present), 32'(exp_colour));
        check_snapshot("b2b_snap");

        // Error counter saturation
        for (int b = 0; b < 300; b++) begin
            send_word(32'hAAAA_AAAA);
            send_word(32'hFFFF_FFFF);
            exp_err = sat_inc(exp_err);
        end
        idle(2);
        check("sat_err", 32'(err_count), 32'(exp_err));
        check("sat_err255", 32'(err_count), 32'd255);
        check("sat_cnt", 32'(msg_count), 32'(exp_cnt));

        // Asynchronous reset in the middle of a message
        rd_index = 5'd0; step();
        random_pairs(); build_msg();
        send_range(0, 10, 0);
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_ready", 32'(msg_ready), 32'd0);
        check("arst_rd", 32'(rd_data), 32'd0);
        check("arst_snapv", 32'(snap_valid), 32'd0);
        check("arst_colour", 32'(colour_present), 32'd0);
        check("arst_err", 32'(err_count), 32'd0);
        check("arst_cnt", 32'(msg_count), 32'd0);
        msg_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        send_range(11, 30, 0);
        idle(2);
        check_status("arst_tail");
        check_snapshot("arst_snap");
        random_pairs(); build_msg();
        send_range(0, 30, 0);
        finish_commit("arst_new");
        check("arst_new_cnt1", 32'(msg_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
